// File: rtl/raisin64_gpio_if.sv
// CPU memory-bus slave port for raisin64_gpio: request qualified by sel & addr_valid,
// answered by a one-cycle registered ready/rdata.
interface raisin64_gpio_if;
    logic        sel;
    logic        addr_valid;
    logic [63:0] addr;
    logic        write;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        ready;

    modport master (output sel, addr_valid, addr, write, wdata, input rdata, ready);
    modport slave  (input sel, addr_valid, addr, write, wdata, output rdata, ready);
endinterface

// File: rtl/raisin64_gpio.sv
// Memory-mapped GPIO: output register with atomic set/clear, input synchroniser,
// optional per-bit edge detection with level irq when RAISIN64_GPIO_IRQ_EN is defined.
module raisin64_gpio #(
    parameter int                   OUT_WIDTH   = 16,
    parameter int                   IN_WIDTH    = 16,
    parameter int                   SYNC_STAGES = 2,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET   = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    raisin64_gpio_if.slave       bus,
    input  logic [IN_WIDTH-1:0]  gpio_in,
    output logic [OUT_WIDTH-1:0] gpio_out,
    output logic                 irq
);
    localparam logic [2:0] OFF_OUT  = 3'd0;
    localparam logic [2:0] OFF_SET  = 3'd1;
    localparam logic [2:0] OFF_CLR  = 3'd2;
    localparam logic [2:0] OFF_IN   = 3'd3;
    localparam logic [2:0] OFF_STAT = 3'd4;
    localparam logic [2:0] OFF_EN   = 3'd5;
    localparam logic [2:0] OFF_MODE = 3'd6;

    typedef enum logic {ST_IDLE, ST_ACK} state_t;

    state_t                             state_reg, state_next;
    logic [OUT_WIDTH-1:0]               out_reg, out_next;
    logic [63:0]                        rdata_reg, rdata_next;
    logic [SYNC_STAGES-1:0][IN_WIDTH-1:0] sync_reg;
    logic [IN_WIDTH-1:0]                sync_in;
    logic [63:0]                        rd_value;
    logic [2:0]                         reg_off;
    logic [OUT_WIDTH-1:0]               wdata_out;
    logic                               req;
    logic                               wr_fire;
    logic                               unused_bits;

    assign req       = bus.sel & bus.addr_valid;
    assign reg_off   = bus.addr[5:3];
    assign wdata_out = bus.wdata[OUT_WIDTH-1:0];
    assign sync_in   = sync_reg[SYNC_STAGES-1];

    // Only the register offset is decoded; everything else on the bus is don't-care.
    assign unused_bits = &{1'b0, bus.addr[63:6], bus.addr[2:0], bus.wdata};

`ifdef RAISIN64_GPIO_IRQ_EN
    logic [IN_WIDTH-1:0] prev_reg, status_reg, en_reg, mode_reg;
    logic [IN_WIDTH-1:0] edge_event, w1c_mask, status_next;
    logic [IN_WIDTH-1:0] wdata_in;
    logic                irq_reg;

    assign wdata_in = bus.wdata[IN_WIDTH-1:0];

    generate
        for (genvar gi = 0; gi < IN_WIDTH; gi++) begin : g_edge
            assign edge_event[gi] = mode_reg[gi] ? (sync_in[gi] & ~prev_reg[gi])
                                                 : (~sync_in[gi] & prev_reg[gi]);
        end
    endgenerate

    // A new event on a bit overrides a coincident W1C of that bit.
    assign w1c_mask    = (wr_fire && reg_off == OFF_STAT) ? wdata_in : '0;
    assign status_next = (status_reg & ~w1c_mask) | edge_event;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg   <= '0;
            status_reg <= '0;
            en_reg     <= '0;
            mode_reg   <= '0;
            irq_reg    <= 1'b0;
        end else begin
            prev_reg   <= sync_in;
            status_reg <= status_next;
            irq_reg    <= |(status_reg & en_reg);
            if (wr_fire && reg_off == OFF_EN)   en_reg   <= wdata_in;
            if (wr_fire && reg_off == OFF_MODE) mode_reg <= wdata_in;
        end
    end

    assign irq = irq_reg;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_value = '0;
        case (reg_off)
            OFF_OUT:  rd_value = 64'(out_reg);
            OFF_IN:   rd_value = 64'(sync_in);
`ifdef RAISIN64_GPIO_IRQ_EN
            OFF_STAT: rd_value = 64'(status_reg);
            OFF_EN:   rd_value = 64'(en_reg);
            OFF_MODE: rd_value = 64'(mode_reg);
`endif
            default:  rd_value = '0;
        endcase
    end

    // rdata defaults to zero so it is only non-zero during the ACK cycle of a read.
    always_comb begin
        state_next = state_reg;
        rdata_next = '0;
        wr_fire    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    state_next = ST_ACK;
                    wr_fire    = bus.write;
                    if (!bus.write) rdata_next = rd_value;
                end
            end
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        out_next = out_reg;
        if (wr_fire) begin
            case (reg_off)
                OFF_OUT: out_next = wdata_out;
                OFF_SET: out_next = out_reg | wdata_out;
                OFF_CLR: out_next = out_reg & ~wdata_out;
                default: out_next = out_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            out_reg   <= OUT_RESET;
            rdata_reg <= '0;
            sync_reg  <= '0;
        end else begin
            state_reg <= state_next;
            out_reg   <= out_next;
            rdata_reg <= rdata_next;
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], gpio_in};
        end
    end

    assign bus.ready = (state_reg == ST_ACK);
    assign bus.rdata = rdata_reg;
    assign gpio_out  = out_reg;
endmodule

// File: tb/tb_raisin64_gpio.sv
// Randomised self-checking bench for raisin64_gpio against a register-level reference model.
module tb_raisin64_gpio;
    localparam int S = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] gpio_in = '0;
    logic [15:0] gpio_out;
    logic        irq;

    raisin64_gpio_if bus();

    raisin64_gpio #(
        .OUT_WIDTH(16), .IN_WIDTH(16), .SYNC_STAGES(S), .OUT_RESET(16'h00A5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: register contents plus a history of sampled inputs.
    logic [15:0] out_m = 16'h00A5;
    logic [15:0] en_m = '0;
    logic [15:0] mode_m = '0;
    logic [15:0] w1c_mask = '0;
    logic [15:0] status_m;
    logic        irq_m;
    logic [15:0] hist [0:7];
    wire  [15:0] cur_m  = hist[S-1];
    wire  [15:0] prev_m = hist[S];
    wire  [15:0] ev_m   = (mode_m & cur_m & ~prev_m) | (~mode_m & ~cur_m & prev_m);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) hist[i] <= '0;
            status_m <= '0;
            irq_m    <= 1'b0;
        end else begin
            hist[0] <= gpio_in;
            for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
`ifdef RAISIN64_GPIO_IRQ_EN
            status_m <= (status_m & ~w1c_mask) | ev_m;
            irq_m    <= |(status_m & en_m);
`endif
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_read(input logic [2:0] off);
        case (off)
            3'd0: return {48'h0, out_m};
            3'd3: return {48'h0, cur_m};
`ifdef RAISIN64_GPIO_IRQ_EN
            3'd4: return {48'h0, status_m};
            3'd5: return {48'h0, en_m};
            3'd6: return {48'h0, mode_m};
`endif
            default: return 64'h0;
        endcase
    endfunction

    // Called #1 after a rising edge with the DUT idle; returns #1 after the edge following ACK.
    task automatic access(input logic [2:0] off, input logic wr, input logic [63:0] data,
                          output logic [63:0] got);
        logic [63:0] exp;
        logic [63:0] a;
        a = {$urandom, $urandom};
        a[5:3] = off;
        bus.sel = 1'b1; bus.addr_valid = 1'b1; bus.addr = a; bus.write = wr; bus.wdata = data;
`ifdef RAISIN64_GPIO_IRQ_EN
        if (wr && off == 3'd4) w1c_mask = data[15:0];
`endif
        exp = model_read(off);
        @(posedge clk); #1;
        bus.sel = 1'b0; bus.addr_valid = 1'b0; bus.wdata = {$urandom, $urandom};
        w1c_mask = '0;
        if (wr) begin
            case (off)
                3'd0: out_m = data[15:0];
                3'd1: out_m = out_m | data[15:0];
                3'd2: out_m = out_m & ~data[15:0];
`ifdef RAISIN64_GPIO_IRQ_EN
                3'd5: en_m = data[15:0];
                3'd6: mode_m = data[15:0];
`endif
                default: ;
            endcase
        end
        got = bus.rdata;
        check_val("ready_ack", {63'h0, bus.ready}, 64'h1);
        check_val(wr ? "rdata_on_write" : "rdata_read", bus.rdata, wr ? 64'h0 : exp);
        check_val("gpio_out", {48'h0, gpio_out}, {48'h0, out_m});
        check_val("irq", {63'h0, irq}, {63'h0, irq_m});
        $display("access off=%0d wr=%0b wdata=%h rdata=%h gpio_out=%h irq=%0b",
                 off, wr, data, got, gpio_out, irq);
        @(posedge clk); #1;
        check_val("ready_idle", {63'h0, bus.ready}, 64'h0);
        check_val("rdata_idle", bus.rdata, 64'h0);
    endtask

    initial begin
        logic [63:0] got;
        logic [63:0] exp;
        bus.sel = 1'b0; bus.addr_valid = 1'b0; bus.addr = '0; bus.write = 1'b0; bus.wdata = '0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state and first read
        check_val("reset_gpio_out", {48'h0, gpio_out}, 64'h00A5);
        check_val("reset_ready", {63'h0, bus.ready}, 64'h0);
        check_val("reset_rdata", bus.rdata, 64'h0);
        check_val("reset_irq", {63'h0, irq}, 64'h0);
        access(3'd0, 1'b0, 64'h0, got);
        check_val("read_out_reset", got, 64'h00A5);

        // Write / set / clear sequence
        access(3'd0, 1'b1, 64'h1234, got);
        check_val("out_write", {48'h0, gpio_out}, 64'h1234);
        access(3'd1, 1'b1, 64'h000F, got);
        check_val("out_set", {48'h0, gpio_out}, 64'h123F);
        access(3'd2, 1'b1, 64'h1030, got);
        check_val("out_clr", {48'h0, gpio_out}, 64'h020F);

        // Synchroniser latency
        gpio_in = 16'h1234;
        access(3'd3, 1'b0, 64'h0, got);
        check_val("sync_lat_early", got, 64'h0);
        access(3'd3, 1'b0, 64'h0, got);
        check_val("sync_lat_before3", got, 64'h0);
        access(3'd3, 1'b0, 64'h0, got);
        check_val("sync_lat_after3", got, 64'h1234);

        // Request held for four cycles: two reads, ready 0,1,0,1
        exp = model_read(3'd0);
        bus.sel = 1'b1; bus.addr_valid = 1'b1; bus.addr = 64'h0; bus.write = 1'b0;
        check_val("hold_ready_c0", {63'h0, bus.ready}, 64'h0);
        @(posedge clk); #1;
        check_val("hold_ready_c1", {63'h0, bus.ready}, 64'h1);
        check_val("hold_rdata_c1", bus.rdata, exp);
        @(posedge clk); #1;
        check_val("hold_ready_c2", {63'h0, bus.ready}, 64'h0);
        @(posedge clk); #1;
        check_val("hold_ready_c3", {63'h0, bus.ready}, 64'h1);
        check_val("hold_rdata_c3", bus.rdata, exp);
        bus.sel = 1'b0; bus.addr_valid = 1'b0;
        @(posedge clk); #1;
        check_val("hold_ready_c4", {63'h0, bus.ready}, 64'h0);

        // Read-only / reserved / write-only offsets
        access(3'd3, 1'b1, 64'hFFFF, got);
        access(3'd7, 1'b1, 64'hFFFF, got);
        access(3'd1, 1'b0, 64'h0, got);
        check_val("wo_read_zero", got, 64'h0);
        check_val("ignored_writes", {48'h0, gpio_out}, 64'h020F);

`ifdef RAISIN64_GPIO_IRQ_EN
        // Rising edge on bit 0: status after S+1 clocks, irq one clock later
        gpio_in = 16'h0;
        access(3'd5, 1'b1, 64'h1, got);
        access(3'd6, 1'b1, 64'h1, got);
        repeat (S + 2) @(posedge clk);
        #1;
        access(3'd4, 1'b1, 64'hFFFF, got);
        repeat (2) @(posedge clk);
        #1;
        gpio_in = 16'h0001;
        repeat (S + 1) @(posedge clk);
        #1;
        check_val("irq_not_yet", {63'h0, irq}, 64'h0);
        @(posedge clk); #1;
        check_val("irq_assert", {63'h0, irq}, 64'h1);
        access(3'd4, 1'b0, 64'h0, got);
        check_val("status_set", got, 64'h1);
        access(3'd4, 1'b1, 64'h1, got);
        check_val("irq_cleared", {63'h0, irq}, 64'h0);
        // W1C coincident with a new rising edge
        gpio_in = 16'h0;
        repeat (S + 3) @(posedge clk);
        #1;
        gpio_in = 16'h0001;
        repeat (S) @(posedge clk);
        #1;
        access(3'd4, 1'b1, 64'h1, got);
        access(3'd4, 1'b0, 64'h0, got);
        check_val("w1c_event_wins", got, 64'h1);
`endif

        // Randomised traffic
        for (int t = 0; t < 150; t++) begin
            int gap;
            logic [2:0] off;
            logic wr;
            logic [63:0] data;
            if ($urandom_range(0, 2) == 0) gpio_in = 16'($urandom);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 1) == 1) begin
                    bus.sel = 1'b1; bus.addr_valid = 1'b0;
                end else begin
                    bus.sel = 1'b0; bus.addr_valid = 1'b1;
                end
                @(posedge clk); #1;
                check_val("partial_req_no_ready", {63'h0, bus.ready}, 64'h0);
            end
            bus.sel = 1'b0; bus.addr_valid = 1'b0;
            off  = 3'($urandom_range(0, 7));
            wr   = 1'($urandom_range(0, 1));
            data = {$urandom, $urandom};
            access(off, wr, data, got);
        end

        // Reset asserted during ACK: ready drops at once, registers return to reset values
        bus.sel = 1'b1; bus.addr_valid = 1'b1; bus.addr = 64'h0; bus.write = 1'b0;
        @(posedge clk); #1;
        bus.sel = 1'b0; bus.addr_valid = 1'b0;
        check_val("pre_reset_ready", {63'h0, bus.ready}, 64'h1);
        #1 rst_n = 1'b0;
        #1;
        check_val("mid_reset_ready", {63'h0, bus.ready}, 64'h0);
        check_val("mid_reset_rdata", bus.rdata, 64'h0);
        check_val("mid_reset_gpio_out", {48'h0, gpio_out}, 64'h00A5);
        check_val("mid_reset_irq", {63'h0, irq}, 64'h0);
        out_m = 16'h00A5; en_m = '0; mode_m = '0;
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        access(3'd0, 1'b0, 64'h0, got);
        check_val("post_reset_read", got, 64'h00A5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
